mem_port_arb: RTL and testbench

- Shares one Avalon port of the quad-port LPDDR2 interface (port 0 of ram_int_4p) between three requesters: camera 1 capture writes, camera 2 capture writes, and HDMI display-refresh reads.
- Performs round-robin arbitration with an urgent override for the display. Grants bounded bursts of single-word transactions.
- Tracks outstanding reads and returns read data to the display path.
- Sits between the capture/frame-buffer logic and the memory interface, all on clk_25_2m.

---
 rtl/mem_port_arb.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// Shares one LPDDR2 Avalon port between two camera write streams and the display read stream:
// round-robin with a display-urgent override, bounded bursts, and read-return tracking.
module mem_port_arb #(
   parameter int ADDR_W     = 29,
   parameter int DATA_W     = 32,
   parameter int BURST_LEN  = 8,
   parameter int MAX_RD_OUT = 4
) (
   input  logic              clk_25_2m,
   input  logic              reset,
   input  logic              ram_rdy,
   input  logic              cam0_req,
   input  logic [ADDR_W-1:0] cam0_addr,
   input  logic [DATA_W-1:0] cam0_data,
   output logic              cam0_ack,
   input  logic              cam1_req,
   input  logic [ADDR_W-1:0] cam1_addr,
   input  logic [DATA_W-1:0] cam1_data,
   output logic              cam1_ack,
   input  logic              disp_req,
   input  logic              disp_urgent,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_ack,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_rvalid,
   input  logic              avl_ready,
   input  logic [DATA_W-1:0] avl_rdata,
   input  logic              avl_rdata_valid,
   output logic [ADDR_W-1:0] avl_addr,
   output logic [DATA_W-1:0] avl_wdata,
   output logic              avl_write_req,
   output logic              avl_read_req,
   output logic [1:0]        grant,
   output logic              rd_err
);
   typedef enum logic {IDLE, ISSUE} state_t;

   localparam logic [1:0] G_CAM0 = 2'd0;
   localparam logic [1:0] G_CAM1 = 2'd1;
   localparam logic [1:0] G_DISP = 2'd2;
   localparam logic [1:0] G_NONE = 2'd3;
   localparam logic [8:0] BURST_LIM = 9'(BURST_LEN);
   localparam logic [3:0] RD_LIM    = 4'(MAX_RD_OUT);

   state_t            state_reg, state_next;
   logic [1:0]        ptr_reg, ptr_next, grant_next, sel;
   logic [7:0]        beats_reg, beats_next;
   logic [8:0]        beats_inc;
   logic [3:0]        out_reg, out_next;
   logic [ADDR_W-1:0] addr_next, win_addr, own_addr;
   logic [DATA_W-1:0] wdata_next, win_data, own_data;
   logic              write_next, read_next;
   logic              accept, rd_accept, rd_ret;
   logic              el_cam0, el_cam1, el_disp, own_req, cont;

   assign accept    = (state_reg == ISSUE) && avl_ready;
   assign rd_accept = accept && (grant == G_DISP);
   // A return with nothing outstanding is flagged, never allowed to wrap the counter.
   assign rd_ret    = avl_rdata_valid && (out_reg != 4'd0);
   assign out_next  = out_reg + {3'd0, rd_accept} - {3'd0, rd_ret};
   assign beats_inc = {1'b0, beats_reg} + 9'd1;

   assign el_cam0 = cam0_req && ram_rdy;
   assign el_cam1 = cam1_req && ram_rdy;
   assign el_disp = disp_req && ram_rdy && (out_reg < RD_LIM);

   assign cam0_ack = accept && (grant == G_CAM0);
   assign cam1_ack = accept && (grant == G_CAM1);
   assign disp_ack = accept && (grant == G_DISP);

   always_comb begin
      sel = G_NONE;
      if (disp_urgent && el_disp) begin
         sel = G_DISP;
      end else begin
         case (ptr_reg)
            G_CAM0:  sel = el_cam0 ? G_CAM0 : el_cam1 ? G_CAM1 : el_disp ? G_DISP : G_NONE;
            G_CAM1:  sel = el_cam1 ? G_CAM1 : el_disp ? G_DISP : el_cam0 ? G_CAM0 : G_NONE;
            default: sel = el_disp ? G_DISP : el_cam0 ? G_CAM0 : el_cam1 ? G_CAM1 : G_NONE;
         endcase
      end
   end

   always_comb begin
      win_addr = disp_addr;
      win_data = '0;
      case (sel)
         G_CAM0:  begin win_addr = cam0_addr; win_data = cam0_data; end
         G_CAM1:  begin win_addr = cam1_addr; win_data = cam1_data; end
         default: ;
      endcase
   end

   always_comb begin
      own_req  = disp_req;
      own_addr = disp_addr;
      own_data = '0;
      case (grant)
         G_CAM0:  begin own_req = cam0_req; own_addr = cam0_addr; own_data = cam0_data; end
         G_CAM1:  begin own_req = cam1_req; own_addr = cam1_addr; own_data = cam1_data; end
         default: ;
      endcase
   end

   // Cameras yield to an urgent display; the display yields when its read window is full.
   assign cont = own_req && (beats_inc < BURST_LIM) && ram_rdy &&
                 ((grant == G_DISP) ? (out_next < RD_LIM) : !disp_urgent);

   always_comb begin
      state_next = state_reg;
      grant_next = grant;
      ptr_next   = ptr_reg;
      beats_next = beats_reg;
      addr_next  = avl_addr;
      wdata_next = avl_wdata;
      write_next = avl_write_req;
      read_next  = avl_read_req;
      case (state_reg)
         IDLE: begin
            if (sel != G_NONE) begin
               addr_next  = win_addr;
               wdata_next = win_data;
               write_next = (sel != G_DISP);
               read_next  = (sel == G_DISP);
               grant_next = sel;
               beats_next = 8'd0;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (accept) begin
               beats_next = beats_inc[7:0];
               if (cont) begin
                  addr_next  = own_addr;
                  wdata_next = own_data;
               end else begin
                  write_next = 1'b0;
                  read_next  = 1'b0;
                  grant_next = G_NONE;
                  ptr_next   = (grant == G_DISP) ? G_CAM0 : grant + 2'd1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_25_2m) begin
      if (!reset) begin
         state_reg     <= IDLE;
         grant         <= G_NONE;
         ptr_reg       <= G_CAM0;
         beats_reg     <= 8'd0;
         out_reg       <= 4'd0;
         avl_addr      <= '0;
         avl_wdata     <= '0;
         avl_write_req <= 1'b0;
         avl_read_req  <= 1'b0;
         disp_rdata    <= '0;
         disp_rvalid   <= 1'b0;
         rd_err        <= 1'b0;
      end else begin
         state_reg     <= state_next;
         grant         <= grant_next;
         ptr_reg       <= ptr_next;
         beats_reg     <= beats_next;
         out_reg       <= out_next;
         avl_addr      <= addr_next;
         avl_wdata     <= wdata_next;
         avl_write_req <= write_next;
         avl_read_req  <= read_next;
         disp_rdata    <= avl_rdata;
         disp_rvalid   <= avl_rdata_valid;
         rd_err        <= rd_err | (avl_rdata_valid && (out_reg == 4'd0));
      end
   end
endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios with literal expectations plus a long random run,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arb;
   localparam int AW = 29;
   localparam int DW = 32;
   localparam int BL = 8;
   localparam int MO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b0, ram_rdy = 1'b0;
   logic          cam0_req = 1'b0, cam1_req = 1'b0, disp_req = 1'b0, disp_urgent = 1'b0;
   logic [AW-1:0] cam0_addr = '0, cam1_addr = '0, disp_addr = '0;
   logic [DW-1:0] cam0_data = '0, cam1_data = '0, avl_rdata = '0;
   logic          avl_ready = 1'b0, avl_rdata_valid = 1'b0;
   logic          cam0_ack, cam1_ack, disp_ack, disp_rvalid, avl_write_req, avl_read_req, rd_err;
   logic [DW-1:0] disp_rdata, avl_wdata;
   logic [AW-1:0] avl_addr;
   logic [1:0]    grant;

   mem_port_arb #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .MAX_RD_OUT(MO)) dut (
      .clk_25_2m(clk), .reset(reset), .ram_rdy(ram_rdy),
      .cam0_req(cam0_req), .cam0_addr(cam0_addr), .cam0_data(cam0_data), .cam0_ack(cam0_ack),
      .cam1_req(cam1_req), .cam1_addr(cam1_addr), .cam1_data(cam1_data), .cam1_ack(cam1_ack),
      .disp_req(disp_req), .disp_urgent(disp_urgent), .disp_addr(disp_addr), .disp_ack(disp_ack),
      .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
      .avl_ready(avl_ready), .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid),
      .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_write_req(avl_write_req),
      .avl_read_req(avl_read_req), .grant(grant), .rd_err(rd_err)
   );

   int tests = 0, errors = 0;
   int cnt0 = 0, cnt1 = 0, cnt2 = 0;

   // Model: who owns the port, how many beats it has had, reads in flight, expected outputs.
   int            m_owner = 3, m_ptr = 0, m_beats = 0, m_out = 0;
   bit            m_err = 0, e_wr = 0, e_rd = 0, e_rvalid = 0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0, e_rdata = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit req_of(input int k);
      return (k == 0) ? cam0_req : (k == 1) ? cam1_req : disp_req;
   endfunction

   function automatic int pick(input int outs);
      bit el [3];
      for (int k = 0; k < 3; k++)
         el[k] = req_of(k) && ram_rdy && (k != 2 || outs < MO);
      if (disp_urgent && el[2]) return 2;
      for (int i = 0; i < 3; i++)
         if (el[(m_ptr + i) % 3]) return (m_ptr + i) % 3;
      return 3;
   endfunction

   task automatic load(input int w);
      e_addr  = (w == 0) ? cam0_addr : (w == 1) ? cam1_addr : disp_addr;
      e_wdata = (w == 0) ? cam0_data : (w == 1) ? cam1_data : '0;
   endtask

   // Compare then advance the model, mid-cycle while inputs are stable.
   initial begin
      forever begin
         bit acc;
         int old_out, w;
         @(negedge clk);
         acc = (m_owner != 3) && avl_ready;
         chk("grant", 64'(grant), 64'(m_owner));
         chk("avl_addr", 64'(avl_addr), 64'(e_addr));
         chk("avl_wdata", 64'(avl_wdata), 64'(e_wdata));
         chk("avl_write_req", 64'(avl_write_req), 64'(e_wr));
         chk("avl_read_req", 64'(avl_read_req), 64'(e_rd));
         chk("cam0_ack", 64'(cam0_ack), 64'(acc && m_owner == 0));
         chk("cam1_ack", 64'(cam1_ack), 64'(acc && m_owner == 1));
         chk("disp_ack", 64'(disp_ack), 64'(acc && m_owner == 2));
         chk("disp_rdata", 64'(disp_rdata), 64'(e_rdata));
         chk("disp_rvalid", 64'(disp_rvalid), 64'(e_rvalid));
         chk("rd_err", 64'(rd_err), 64'(m_err));
         if (cam0_ack) cnt0++;
         if (cam1_ack) cnt1++;
         if (disp_ack) cnt2++;
         if (!reset) begin
            m_owner = 3; m_ptr = 0; m_beats = 0; m_out = 0; m_err = 0;
            e_addr = '0; e_wdata = '0; e_wr = 0; e_rd = 0; e_rdata = '0; e_rvalid = 0;
         end else begin
            old_out = m_out;
            if (avl_rdata_valid && old_out == 0) m_err = 1;
            m_out = old_out + ((acc && m_owner == 2) ? 1 : 0) - ((avl_rdata_valid && old_out > 0) ? 1 : 0);
            e_rdata  = avl_rdata;
            e_rvalid = avl_rdata_valid;
            if (m_owner == 3) begin
               w = pick(old_out);
               if (w != 3) begin
                  m_owner = w; load(w); e_wr = (w != 2); e_rd = (w == 2); m_beats = 0;
               end
            end else if (avl_ready) begin
               m_beats++;
               if (req_of(m_owner) && m_beats < BL && ram_rdy &&
                   ((m_owner == 2) ? (m_out < MO) : !disp_urgent)) begin
                  load(m_owner);
               end else begin
                  e_wr = 0; e_rd = 0; m_ptr = (m_owner + 1) % 3; m_owner = 3;
               end
            end
         end
      end
   end

   // Each requester presents the word numbered by its ack count.
   task automatic tick();
      @(posedge clk);
      #1;
      cam0_addr = 29'h0100000 + 29'(cnt0);
      cam0_data = 32'hA500_0000 ^ (32'(cnt0) * 32'h0001_0003);
      cam1_addr = 29'h0200000 + 29'(cnt1);
      cam1_data = 32'h5A00_0000 ^ (32'(cnt1) * 32'h0003_0001);
      disp_addr = 29'h0300000 + 29'(cnt2);
      avl_rdata = $urandom;
   endtask

   task automatic do_reset();
      reset = 1'b0; cam0_req = 0; cam1_req = 0; disp_req = 0; disp_urgent = 0;
      avl_rdata_valid = 0; avl_ready = 0; ram_rdy = 0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   int b, hist [80], gq[$], prev_g;
   bit seen1;
   logic [AW-1:0] held_addr;
   logic [DW-1:0] held_data;

   initial begin
      tick();
      chk("reset_grant", 64'(grant), 64'd3);
      chk("reset_wr", 64'(avl_write_req), 64'd0);

      // cam0 alone, 20 words, always accepted.
      do_reset(); ram_rdy = 1; avl_ready = 1; b = cnt0;
      for (int c = 0; c < 30; c++) begin
         if (c > 0) tick();
         cam0_req = (cnt0 - b) < 19;
         if (c == 9) begin
            chk("s1_gap_wr", 64'(avl_write_req), 64'd0);
            chk("s1_gap_grant", 64'(grant), 64'd3);
         end
         if (c == 10) chk("s1_first_burst", 64'(cnt0 - b), 64'd8);
      end
      tick();
      chk("s1_total", 64'(cnt0 - b), 64'd20);

      // Urgent display cuts a cam0 burst after its third beat.
      do_reset(); ram_rdy = 1; avl_ready = 1; disp_req = 1; b = cnt0;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) tick();
         cam0_req = 1; disp_urgent = (c >= 3);
         if (c == 5) begin
            chk("s2_grant_disp", 64'(grant), 64'd2);
            chk("s2_read_req", 64'(avl_read_req), 64'd1);
         end
         if (c == 6) chk("s2_cam0_beats", 64'(cnt0 - b), 64'd3);
      end

      // Read window: four reads without returns, one more after a single return.
      do_reset(); ram_rdy = 1; avl_ready = 1; disp_req = 1; b = cnt2;
      for (int c = 0; c < 21; c++) begin
         if (c > 0) tick();
         avl_rdata_valid = (c == 13);
         if (c == 13) avl_rdata = 32'hDEAD_BEEF;
         if (c == 12) begin
            chk("s3_four_reads", 64'(cnt2 - b), 64'd4);
            chk("s3_read_blocked", 64'(avl_read_req), 64'd0);
         end
         if (c == 14) begin
            chk("s3_rdata", 64'(disp_rdata), 64'hDEAD_BEEF);
            chk("s3_rvalid", 64'(disp_rvalid), 64'd1);
         end
         if (c == 20) begin
            chk("s3_fifth_read", 64'(cnt2 - b), 64'd5);
            chk("s3_blocked_again", 64'(avl_read_req), 64'd0);
         end
      end

      // Memory stalls for ten cycles; the request must not move.
      do_reset(); ram_rdy = 1; cam1_req = 1; b = cnt1;
      held_addr = cam1_addr; held_data = cam1_data;
      for (int c = 0; c < 15; c++) begin
         if (c > 0) tick();
         avl_ready = (c >= 12);
         if (c >= 1 && c <= 11) cam1_data = $urandom;
         if (c == 6 || c == 12) begin
            chk("s4_addr_held", 64'(avl_addr), 64'(held_addr));
            chk("s4_data_held", 64'(avl_wdata), 64'(held_data));
            chk("s4_wr_held", 64'(avl_write_req), 64'd1);
            chk("s4_no_ack", 64'(cnt1 - b), 64'd0);
         end
         if (c == 13) chk("s4_ack_after", 64'(cnt1 - b), 64'd1);
      end
      cam1_req = 0;

      // Reset in the middle of a burst, then a stray read return.
      do_reset(); ram_rdy = 1; avl_ready = 1;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) tick();
         reset = (c != 3); cam0_req = (c < 4); avl_rdata_valid = (c == 6);
         if (c == 4) begin
            chk("s5_wr_cleared", 64'(avl_write_req), 64'd0);
            chk("s5_grant_none", 64'(grant), 64'd3);
            chk("s5_ack_quiet", 64'(cam0_ack), 64'd0);
         end
         if (c == 7) chk("s5_rd_err", 64'(rd_err), 64'd1);
      end

      // Everyone requesting; reads return five cycles after acceptance.
      do_reset(); ram_rdy = 1; avl_ready = 1; cam0_req = 1; cam1_req = 1; disp_req = 1;
      b = cnt0; prev_g = 3; seen1 = 0; gq.delete();
      for (int c = 0; c < 80; c++) begin
         if (c > 0) tick();
         hist[c] = cnt2;
         avl_rdata_valid = (c >= 5) && (hist[c-4] - hist[c-5] == 1);
         if (32'(grant) != prev_g && grant != 2'd3) begin
            gq.push_back(int'(grant));
            if (grant == 2'd1 && !seen1) begin
               chk("s6_cam0_burst", 64'(cnt0 - b), 64'd8);
               seen1 = 1;
            end
         end
         prev_g = int'(grant);
      end
      for (int i = 0; i < 6; i++)
         chk("s6_grant_order", 64'((i < gq.size()) ? gq[i] : 99), 64'(i % 3));

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         tick();
         reset     = ($urandom_range(0, 499) != 0);
         ram_rdy   = ($urandom_range(0, 9) != 0);
         avl_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 7) == 0) cam0_req = ~cam0_req;
         if ($urandom_range(0, 7) == 0) cam1_req = ~cam1_req;
         if ($urandom_range(0, 7) == 0) disp_req = ~disp_req;
         disp_urgent = ($urandom_range(0, 9) == 0);
         avl_rdata_valid = (m_out > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 199) == 0);
      end
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
